// File: rtl/new_flow_installer_pkg.sv
// new_flow_installer_pkg
// Shared types for the new-flow installer: field widths, the lookup-table
// entry type, the buffered notification record and the install FSM states.
package new_flow_installer_pkg;

   localparam int FLOW_ID_W               = 4;
   localparam int FLOW_LOOKUP_ENTRY_WIDTH = 16;
   localparam int ACK_NUM_WIDTH           = 32;
   localparam int NUM_FLOWS               = 1 << FLOW_ID_W;

   typedef logic [FLOW_LOOKUP_ENTRY_WIDTH-1:0] flow_lookup_entry;

   typedef struct packed {
      logic [FLOW_ID_W-1:0]     flowid;
      flow_lookup_entry         lookup_entry;
      logic [ACK_NUM_WIDTH-1:0] init_ack_num;
   } new_flow_install_rec;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WR_LOOKUP = 2'd1,
      ST_WR_STATE  = 2'd2
   } install_state_e;

endpackage

// File: rtl/new_flow_installer_if.sv
// new_flow_installer_if
// Table-write handshakes driven by the installer.
//   lookup_wr_val/rdy, lookup_wr_flowid, lookup_wr_entry : flow lookup table write
//   state_init_val/rdy, state_init_flowid, state_init_ack_num : per-flow state init
// master = installer side, slave = table side.
interface new_flow_installer_if;
   import new_flow_installer_pkg::*;

   logic                     lookup_wr_val;
   logic                     lookup_wr_rdy;
   logic [FLOW_ID_W-1:0]     lookup_wr_flowid;
   flow_lookup_entry         lookup_wr_entry;

   logic                     state_init_val;
   logic                     state_init_rdy;
   logic [FLOW_ID_W-1:0]     state_init_flowid;
   logic [ACK_NUM_WIDTH-1:0] state_init_ack_num;

   modport master (
      output lookup_wr_val, lookup_wr_flowid, lookup_wr_entry,
      input  lookup_wr_rdy,
      output state_init_val, state_init_flowid, state_init_ack_num,
      input  state_init_rdy
   );

   modport slave (
      input  lookup_wr_val, lookup_wr_flowid, lookup_wr_entry,
      output lookup_wr_rdy,
      input  state_init_val, state_init_flowid, state_init_ack_num,
      output state_init_rdy
   );

endinterface

// File: rtl/new_flow_install_fifo.sv
// new_flow_install_fifo
// Synchronous show-ahead FIFO of new_flow_install_rec.
//   clk, rst         : clock, synchronous active-high reset (flushes pointers)
//   push, push_data  : write strobe and record (caller guarantees room)
//   pop              : advance head (caller guarantees non-empty)
//   head             : record at the head of the queue
//   full, empty      : occupancy flags
module new_flow_install_fifo
   import new_flow_installer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  new_flow_install_rec push_data,
   input  logic                pop,
   output new_flow_install_rec head,
   output logic                full,
   output logic                empty
);

   localparam int AW = $clog2(DEPTH);

   new_flow_install_rec mem [DEPTH];
   // Extra MSB distinguishes full from empty when the index bits match.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/new_flow_installer.sv
// new_flow_installer
// Buffers new-flow notifications and installs each one by writing the lookup
// table and then initialising per-flow receive state. Keeps an active-flow
// bitmap for duplicate rejection and an install counter.
//   clk, rst                   : clock, synchronous active-high reset
//   new_flow_*                 : notification strobe and payload (no backpressure)
//   flow_free_val/flowid       : teardown strobe, clears the flow's active bit
//   tbl                        : lookup write / state init handshakes (master)
//   install_done, dup_drop     : single-cycle event pulses
//   overflow_err               : sticky, a notification was lost to a full FIFO
//   install_cnt                : completed installs, wraps
//
// state        | meaning
// ST_IDLE      | no install in flight; pops the FIFO head when present
// ST_WR_LOOKUP | lookup table write offered, waiting for lookup_wr_rdy
// ST_WR_STATE  | state init offered, waiting for state_init_rdy
module new_flow_installer
   import new_flow_installer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     new_flow_val,
   input  logic [FLOW_ID_W-1:0]     new_flow_flowid,
   input  flow_lookup_entry         new_flow_lookup_entry,
   input  logic [ACK_NUM_WIDTH-1:0] new_flow_init_ack_num,
   input  logic                     flow_free_val,
   input  logic [FLOW_ID_W-1:0]     flow_free_flowid,
   new_flow_installer_if.master     tbl,
   output logic                     install_done,
   output logic                     dup_drop,
   output logic                     overflow_err,
   output logic [31:0]              install_cnt
);

   install_state_e      state_q, state_d;
   new_flow_install_rec work_q;
   new_flow_install_rec head;
   new_flow_install_rec push_rec;
   logic [NUM_FLOWS-1:0] active_bitmap;
   logic fifo_full, fifo_empty;
   logic push, pop, load_work;

   assign push_rec = '{flowid:       new_flow_flowid,
                       lookup_entry: new_flow_lookup_entry,
                       init_ack_num: new_flow_init_ack_num};

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = new_flow_val && !rst && (!fifo_full || pop);

   new_flow_install_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_rec),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign tbl.lookup_wr_val      = (state_q == ST_WR_LOOKUP);
   assign tbl.lookup_wr_flowid   = work_q.flowid;
   assign tbl.lookup_wr_entry    = work_q.lookup_entry;
   assign tbl.state_init_val     = (state_q == ST_WR_STATE);
   assign tbl.state_init_flowid  = work_q.flowid;
   assign tbl.state_init_ack_num = work_q.init_ack_num;

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      load_work    = 1'b0;
      install_done = 1'b0;
      dup_drop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pop = !rst && !fifo_empty;
         end
         ST_WR_LOOKUP: begin
            if (tbl.lookup_wr_rdy) state_d = ST_WR_STATE;
         end
         ST_WR_STATE: begin
            if (tbl.state_init_rdy && !rst) begin
               install_done = 1'b1;
               state_d      = ST_IDLE;
               // Pop the next head straight away to sustain one install per 2 cycles.
               pop          = !fifo_empty;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         // Registered bitmap only: entries still queued are not cross-checked.
         if (active_bitmap[head.flowid]) begin
            dup_drop = 1'b1;
         end else begin
            load_work = 1'b1;
            state_d   = ST_WR_LOOKUP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         work_q        <= '0;
         active_bitmap <= '0;
         install_cnt   <= '0;
         overflow_err  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_work) work_q <= head;
         if (install_done) begin
            active_bitmap[work_q.flowid] <= 1'b1;
            install_cnt                  <= install_cnt + 32'd1;
         end
         // Later assignment wins: a free in the completion cycle leaves the bit clear.
         if (flow_free_val) active_bitmap[flow_free_flowid] <= 1'b0;
         if (new_flow_val && fifo_full && !pop) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_new_flow_installer.sv
module tb_new_flow_installer;
   import new_flow_installer_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     new_flow_val;
   logic [FLOW_ID_W-1:0]     new_flow_flowid;
   flow_lookup_entry         new_flow_lookup_entry;
   logic [ACK_NUM_WIDTH-1:0] new_flow_init_ack_num;
   logic                     flow_free_val;
   logic [FLOW_ID_W-1:0]     flow_free_flowid;
   logic                     install_done, dup_drop, overflow_err;
   logic [31:0]              install_cnt;

   new_flow_installer_if tbl ();

   new_flow_installer #(.FIFO_DEPTH(4)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .new_flow_val          (new_flow_val),
      .new_flow_flowid       (new_flow_flowid),
      .new_flow_lookup_entry (new_flow_lookup_entry),
      .new_flow_init_ack_num (new_flow_init_ack_num),
      .flow_free_val         (flow_free_val),
      .flow_free_flowid      (flow_free_flowid),
      .tbl                   (tbl),
      .install_done          (install_done),
      .dup_drop              (dup_drop),
      .overflow_err          (overflow_err),
      .install_cnt           (install_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   logic [NUM_FLOWS-1:0] model_bitmap;
   logic [31:0]          exp_cnt;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drive point just after the active edge; strobes default low.
   task automatic cyc();
      @(posedge clk);
      #1;
      new_flow_val  = 1'b0;
      flow_free_val = 1'b0;
      rst           = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic notify(input int fid, input logic [15:0] ent, input logic [31:0] ack);
      new_flow_val          = 1'b1;
      new_flow_flowid       = FLOW_ID_W'(fid);
      new_flow_lookup_entry = ent;
      new_flow_init_ack_num = ack;
   endtask

   task automatic do_reset();
      cyc(); rst = 1'b1; settle();
      cyc(); rst = 1'b1; settle();
      model_bitmap = '0;
      exp_cnt      = 0;
   endtask

   task automatic test_reset();
      do_reset();
      cyc(); settle();
      vectors++;
      if ({tbl.lookup_wr_val, tbl.state_init_val, install_done, dup_drop, overflow_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b required 00000",
                  {tbl.lookup_wr_val, tbl.state_init_val, install_done, dup_drop, overflow_err});
      end
      vectors++;
      if ({tbl.lookup_wr_flowid, tbl.lookup_wr_entry, tbl.state_init_flowid, tbl.state_init_ack_num, install_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_payload got lk=%h/%h st=%h/%h cnt=%0d required all 0",
                  tbl.lookup_wr_flowid, tbl.lookup_wr_entry, tbl.state_init_flowid,
                  tbl.state_init_ack_num, install_cnt);
      end
      vectors++;
      if (dut.active_bitmap !== '0) begin
         errors++;
         $display("FAIL reset_bitmap got %h required 0", dut.active_bitmap);
      end
   endtask

   task automatic test_single();
      logic [15:0] ent;
      ent = 16'($urandom);
      tbl.lookup_wr_rdy  = 1'b1;
      tbl.state_init_rdy = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         cyc();
         if (c == 0) notify(5, ent, 32'h1000);
         settle();
         vectors++;
         if ({tbl.lookup_wr_val, tbl.state_init_val, install_done} !== {c == 2, c == 3, c == 3}) begin
            errors++;
            $display("FAIL single_timing cycle %0d got lk/st/done=%b required %b", c,
                     {tbl.lookup_wr_val, tbl.state_init_val, install_done}, {c == 2, c == 3, c == 3});
         end
         if (c == 2) begin
            vectors++;
            if ({tbl.lookup_wr_flowid, tbl.lookup_wr_entry} !== {4'd5, ent}) begin
               errors++;
               $display("FAIL single_lookup_payload got %h/%h required 5/%h",
                        tbl.lookup_wr_flowid, tbl.lookup_wr_entry, ent);
            end
         end
         if (c == 3) begin
            vectors++;
            if ({tbl.state_init_flowid, tbl.state_init_ack_num} !== {4'd5, 32'h1000}) begin
               errors++;
               $display("FAIL single_state_payload got %h/%h required 5/00001000",
                        tbl.state_init_flowid, tbl.state_init_ack_num);
            end
         end
      end
      exp_cnt = exp_cnt + 1;
      model_bitmap[5] = 1'b1;
      vectors++;
      if (install_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL single_cnt got %0d required %0d", install_cnt, exp_cnt);
      end
      vectors++;
      if (dut.active_bitmap !== model_bitmap) begin
         errors++;
         $display("FAIL single_bitmap got %h required %h", dut.active_bitmap, model_bitmap);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ent;
      logic [31:0] ack;
      logic        exp_lk, exp_st;
      ent = 16'($urandom);
      ack = $urandom;
      tbl.state_init_rdy = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         cyc();
         if (c == 0) notify(9, ent, ack);
         tbl.lookup_wr_rdy = !(c >= 2 && c <= 4);
         settle();
         exp_lk = (c >= 2 && c <= 5);
         exp_st = (c == 6);
         vectors++;
         if ({tbl.lookup_wr_val, tbl.state_init_val, install_done} !== {exp_lk, exp_st, exp_st}) begin
            errors++;
            $display("FAIL bp_timing cycle %0d got lk/st/done=%b required %b", c,
                     {tbl.lookup_wr_val, tbl.state_init_val, install_done}, {exp_lk, exp_st, exp_st});
         end
         if (exp_lk) begin
            vectors++;
            if ({tbl.lookup_wr_flowid, tbl.lookup_wr_entry} !== {4'd9, ent}) begin
               errors++;
               $display("FAIL bp_payload_hold cycle %0d got %h/%h required 9/%h", c,
                        tbl.lookup_wr_flowid, tbl.lookup_wr_entry, ent);
            end
         end
         if (exp_st) begin
            vectors++;
            if (tbl.state_init_ack_num !== ack) begin
               errors++;
               $display("FAIL bp_state_ack got %h required %h", tbl.state_init_ack_num, ack);
            end
         end
      end
      exp_cnt = exp_cnt + 1;
      model_bitmap[9] = 1'b1;
      vectors++;
      if (install_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL bp_cnt got %0d required %0d", install_cnt, exp_cnt);
      end
   endtask

   task automatic test_burst();
      int got[$];
      do_reset();
      tbl.lookup_wr_rdy  = 1'b0;
      tbl.state_init_rdy = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         cyc(); notify(10 + c, 16'(c), 32'(c)); settle();
      end
      cyc(); settle();
      vectors++;
      if (overflow_err !== 1'b1) begin
         errors++;
         $display("FAIL burst_overflow got %b required 1", overflow_err);
      end
      for (int n = 0; n < 40; n++) begin
         cyc();
         tbl.lookup_wr_rdy  = 1'b1;
         tbl.state_init_rdy = 1'b1;
         settle();
         if (install_done) got.push_back(int'(tbl.state_init_flowid));
      end
      vectors++;
      if (got.size() != 5) begin
         errors++;
         $display("FAIL burst_count got %0d installs required 5", got.size());
      end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         vectors++;
         if (got[i] != 10 + i) begin
            errors++;
            $display("FAIL burst_order install %0d got flow %0d required %0d", i, got[i], 10 + i);
         end
      end
      for (int i = 0; i < 5; i++) model_bitmap[10 + i] = 1'b1;
      exp_cnt = 5;
      vectors++;
      if ({overflow_err, install_cnt} !== {1'b1, exp_cnt}) begin
         errors++;
         $display("FAIL burst_final got ovf=%b cnt=%0d required ovf=1 cnt=%0d",
                  overflow_err, install_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int when[$];
      tbl.lookup_wr_rdy  = 1'b1;
      tbl.state_init_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (c <= 2) notify(c, 16'hA0 + 16'(c), 32'(c));
         settle();
         if (install_done) when.push_back(c);
      end
      vectors++;
      if (when.size() != 3) begin
         errors++;
         $display("FAIL b2b_count got %0d required 3", when.size());
      end
      for (int i = 0; i < when.size() && i < 3; i++) begin
         vectors++;
         if (when[i] != 3 + 2 * i) begin
            errors++;
            $display("FAIL b2b_spacing install %0d at cycle %0d required %0d", i, when[i], 3 + 2 * i);
         end
      end
      for (int i = 0; i < 3; i++) model_bitmap[i] = 1'b1;
      exp_cnt = exp_cnt + 3;
   endtask

   task automatic test_duplicate();
      int n_done, n_dup, n_lk;
      do_reset();
      tbl.lookup_wr_rdy  = 1'b1;
      tbl.state_init_rdy = 1'b1;
      for (int pass = 0; pass < 3; pass++) begin
         n_done = 0; n_dup = 0; n_lk = 0;
         if (pass == 2) begin
            cyc(); flow_free_val = 1'b1; flow_free_flowid = 4'd3; settle();
         end
         for (int c = 0; c < 8; c++) begin
            cyc();
            if (c == 0) notify(3, 16'h33, 32'h3000 + 32'(pass));
            settle();
            n_done += int'(install_done);
            n_dup  += int'(dup_drop);
            n_lk   += int'(tbl.lookup_wr_val);
         end
         vectors++;
         if ((pass == 1 && {n_done, n_dup, n_lk} !== {32'd0, 32'd1, 32'd0}) ||
             (pass != 1 && {n_done, n_dup, n_lk} !== {32'd1, 32'd0, 32'd1})) begin
            errors++;
            $display("FAIL dup_pass%0d got done=%0d dup=%0d lkcycles=%0d", pass, n_done, n_dup, n_lk);
         end
      end
      exp_cnt = 2;
      model_bitmap[3] = 1'b1;
      vectors++;
      if (install_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL dup_cnt got %0d required %0d", install_cnt, exp_cnt);
      end
   endtask

   task automatic test_free_collision();
      int k;
      tbl.lookup_wr_rdy  = 1'b1;
      tbl.state_init_rdy = 1'b0;
      cyc(); notify(7, 16'h77, 32'h7777); settle();
      k = 0;
      while (!tbl.state_init_val && k < 10) begin
         cyc(); settle(); k++;
      end
      vectors++;
      if (!tbl.state_init_val) begin
         errors++;
         $display("FAIL collide_reach_state got state_init_val=0 required 1 within 10 cycles");
      end
      cyc();
      tbl.state_init_rdy = 1'b1;
      flow_free_val      = 1'b1;
      flow_free_flowid   = 4'd7;
      settle();
      vectors++;
      if (install_done !== 1'b1) begin
         errors++;
         $display("FAIL collide_done got %b required 1", install_done);
      end
      cyc(); settle();
      exp_cnt = exp_cnt + 1;
      model_bitmap[7] = 1'b0;
      vectors++;
      if ({dut.active_bitmap, install_cnt} !== {model_bitmap, exp_cnt}) begin
         errors++;
         $display("FAIL collide_bitmap got %h cnt=%0d required %h cnt=%0d",
                  dut.active_bitmap, install_cnt, model_bitmap, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int k, n_act;
      tbl.lookup_wr_rdy  = 1'b1;
      tbl.state_init_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc(); notify(c == 2 ? 4 : c + 1, 16'h40, 32'h40); settle();
      end
      k = 0;
      while (!tbl.state_init_val && k < 10) begin
         cyc(); settle(); k++;
      end
      cyc(); rst = 1'b1; settle();
      cyc();
      tbl.state_init_rdy = 1'b1;
      settle();
      model_bitmap = '0;
      exp_cnt      = 0;
      vectors++;
      if ({tbl.lookup_wr_val, tbl.state_init_val, install_done, dup_drop, overflow_err,
           tbl.lookup_wr_flowid, tbl.state_init_ack_num, install_cnt} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs got val=%b%b done=%b dup=%b ovf=%b fid=%h ack=%h cnt=%0d required all 0",
                  tbl.lookup_wr_val, tbl.state_init_val, install_done, dup_drop, overflow_err,
                  tbl.lookup_wr_flowid, tbl.state_init_ack_num, install_cnt);
      end
      n_act = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(); settle();
         n_act += int'(install_done) + int'(tbl.lookup_wr_val) + int'(tbl.state_init_val) + int'(dup_drop);
      end
      vectors++;
      if (n_act != 0) begin
         errors++;
         $display("FAIL rstmid_quiet got %0d activity events required 0", n_act);
      end
   endtask

   task automatic test_random();
      int fid, fidf;
      logic [15:0] ent;
      logic [31:0] ack;
      logic exp_dup, seen_dup, seen_done, lk_done, prev_stall, finished;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            fidf = int'($urandom_range(0, 7));
            cyc(); flow_free_val = 1'b1; flow_free_flowid = FLOW_ID_W'(fidf); settle();
            model_bitmap[fidf] = 1'b0;
         end
         fid     = int'($urandom_range(0, 7));
         ent     = 16'($urandom);
         ack     = $urandom;
         exp_dup = model_bitmap[fid];
         seen_dup = 0; seen_done = 0; lk_done = 0; prev_stall = 0; finished = 0;
         for (int n = 0; n < 60 && !finished; n++) begin
            cyc();
            if (n == 0) notify(fid, ent, ack);
            tbl.lookup_wr_rdy  = 1'($urandom_range(0, 1));
            tbl.state_init_rdy = 1'($urandom_range(0, 1));
            settle();
            if (prev_stall) begin
               vectors++;
               if (tbl.lookup_wr_val !== 1'b1) begin
                  errors++;
                  $display("FAIL rnd_val_hold it %0d lookup_wr_val dropped without rdy", it);
               end
            end
            if (tbl.state_init_val) begin
               vectors++;
               if ({lk_done, tbl.state_init_flowid, tbl.state_init_ack_num} !== {1'b1, 4'(fid), ack}) begin
                  errors++;
                  $display("FAIL rnd_state it %0d got lkdone=%b fid=%h ack=%h required 1/%h/%h",
                           it, lk_done, tbl.state_init_flowid, tbl.state_init_ack_num, 4'(fid), ack);
               end
            end
            if (tbl.lookup_wr_val) begin
               vectors++;
               if ({tbl.lookup_wr_flowid, tbl.lookup_wr_entry} !== {4'(fid), ent}) begin
                  errors++;
                  $display("FAIL rnd_lookup it %0d got %h/%h required %h/%h",
                           it, tbl.lookup_wr_flowid, tbl.lookup_wr_entry, 4'(fid), ent);
               end
               if (tbl.lookup_wr_rdy) lk_done = 1'b1;
            end
            prev_stall = tbl.lookup_wr_val && !tbl.lookup_wr_rdy;
            if (dup_drop)     begin seen_dup  = 1'b1; finished = 1'b1; end
            if (install_done) begin seen_done = 1'b1; finished = 1'b1; end
         end
         vectors++;
         if ({seen_dup, seen_done} !== {exp_dup, !exp_dup}) begin
            errors++;
            $display("FAIL rnd_outcome it %0d flow %0d got dup/done=%b%b required %b%b",
                     it, fid, seen_dup, seen_done, exp_dup, !exp_dup);
         end
         if (!exp_dup) begin
            model_bitmap[fid] = 1'b1;
            exp_cnt = exp_cnt + 1;
         end
         cyc(); settle();
         vectors++;
         if (install_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rnd_cnt it %0d got %0d required %0d", it, install_cnt, exp_cnt);
         end
      end
   endtask

   initial begin
      rst                   = 1'b1;
      new_flow_val          = 1'b0;
      new_flow_flowid       = '0;
      new_flow_lookup_entry = '0;
      new_flow_init_ack_num = '0;
      flow_free_val         = 1'b0;
      flow_free_flowid      = '0;
      tbl.lookup_wr_rdy     = 1'b0;
      tbl.state_init_rdy    = 1'b0;
      model_bitmap          = '0;
      exp_cnt               = 0;

      test_reset();
      test_single();
      test_backpressure();
      test_burst();
      test_back_to_back();
      test_duplicate();
      test_free_collision();
      test_reset_mid();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
